// File: rtl/st2bus_pack.sv
// -----------------------------------------------------------------------------
// st2bus_pack
//
// Packs the turbo decoder array's single Avalon-ST beat stream, packet by
// packet, into BUS_DATA-bit words for return to the host bus. Each word carries
// a last flag, a valid-beat count and an error flag (set when a packet is cut
// short by a new start-of-packet). A 2-entry FIFO sits between the packer and
// the host so that host back-pressure only stalls the stream once both entries
// are occupied.
//
// Optional feature (macro ST2BUS_SEQ_EN): adds output bus_seq, a 16-bit packet
// sequence number carried by every word of a packet. It advances each time a
// last=1 word is pushed, including the words of aborted packets.
//
// Ports:
//   clk         clock
//   rst_n       synchronous reset, active low
//   st_data     input beat (ST bits)
//   st_valid    beat valid
//   st_sop      first beat of packet
//   st_eop      last beat of packet
//   st_ready    packer accepts a beat this cycle
//   bus_data    packed word, beat k in bits [k*ST +: ST], unfilled slots zero
//   bus_valid   word valid
//   bus_last    word is the final word of its packet
//   bus_bcnt    number of valid beats in the word
//   bus_err     packet was closed abnormally
//   bus_ready   host accepts the word
//   drop_pulse  one-cycle pulse when a stray beat outside a packet is discarded
//   bus_seq     packet sequence number (only with ST2BUS_SEQ_EN)
// -----------------------------------------------------------------------------
module st2bus_pack #(
  parameter  int ST       = 8,
  parameter  int BUS_DATA = 512,
  localparam int NBEAT    = BUS_DATA / ST,
  localparam int CW       = $clog2(NBEAT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ST-1:0]       st_data,
  input  logic                st_valid,
  input  logic                st_sop,
  input  logic                st_eop,
  output logic                st_ready,
  output logic [BUS_DATA-1:0] bus_data,
  output logic                bus_valid,
  output logic                bus_last,
  output logic [CW-1:0]       bus_bcnt,
  output logic                bus_err,
  input  logic                bus_ready,
  output logic                drop_pulse
`ifdef ST2BUS_SEQ_EN
  ,
  output logic [15:0]         bus_seq
`endif
);

  // S_PEND: an abort cycle whose restarting beat was also an eop. The abort
  // word took this cycle's FIFO slot, so the 1-beat packet held in the
  // accumulator is pushed on the following cycle with the stream stalled.
  typedef enum logic [1:0] {
    S_IDLE,
    S_PKT,
    S_PEND
  } state_t;

  typedef struct packed {
    logic [BUS_DATA-1:0] data;
    logic [CW-1:0]       bcnt;
    logic                last;
    logic                err;
`ifdef ST2BUS_SEQ_EN
    logic [15:0]         seq;
`endif
  } word_t;

  state_t              state_q, state_d;
  logic [BUS_DATA-1:0] acc_q, acc_d;
  logic [BUS_DATA-1:0] acc_ins;
  logic [BUS_DATA-1:0] beat_word;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                drop_q, drop_d;

  logic                push;
  word_t               push_word;

  word_t               fifo_mem [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          fifo_cnt;
  logic                fifo_full;
  word_t               head;
  logic                accept;
  logic                pop;

`ifdef ST2BUS_SEQ_EN
  logic [15:0]         seq_q;
`endif

  // ---------------------------------------------------------------------------
  // Handshakes. Everything below is decoded from registered state, so the
  // ready never depends combinationally on st_valid. Outputs are forced to
  // their idle values while rst_n is low.
  // ---------------------------------------------------------------------------
  assign fifo_full = (fifo_cnt == 2'd2);
  assign st_ready  = rst_n && !fifo_full && (state_q != S_PEND);
  assign accept    = st_valid && st_ready;

  assign head      = fifo_mem[rd_ptr];
  assign bus_valid = rst_n && (fifo_cnt != 2'd0);
  assign pop       = bus_valid && bus_ready;

  assign bus_data  = bus_valid ? head.data : '0;
  assign bus_bcnt  = bus_valid ? head.bcnt : '0;
  assign bus_last  = bus_valid && head.last;
  assign bus_err   = bus_valid && head.err;
  assign drop_pulse = rst_n && drop_q;

`ifdef ST2BUS_SEQ_EN
  assign bus_seq   = bus_valid ? head.seq : '0;
`endif

  // A beat on its own in slot 0, used whenever a fresh packet starts.
  assign beat_word = BUS_DATA'(st_data);

  // Accumulator with the incoming beat merged at slot cnt_q. Slots above
  // cnt_q are already zero because the accumulator is cleared on every push.
  always_comb begin
    acc_ins = acc_q;
    for (int k = 0; k < NBEAT; k++) begin
      if (int'(cnt_q) == k) acc_ins[k*ST +: ST] = st_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Packing state machine: next state, accumulator and FIFO push.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    drop_d    = 1'b0;
    push      = 1'b0;
    push_word = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!st_sop) begin
            // Stray beat outside any packet: discard and flag it.
            drop_d = 1'b1;
          end else if (st_eop) begin
            push           = 1'b1;
            push_word.data = beat_word;
            push_word.bcnt = CW'(1);
            push_word.last = 1'b1;
          end else begin
            acc_d   = beat_word;
            cnt_d   = CW'(1);
            state_d = S_PKT;
          end
        end
      end

      S_PKT: begin
        if (accept) begin
          if (st_sop) begin
            // Abort: close the open word as an error word (possibly empty if
            // the previous word was just emitted) and restart from slot 0.
            push           = 1'b1;
            push_word.data = acc_q;
            push_word.bcnt = cnt_q;
            push_word.last = 1'b1;
            push_word.err  = 1'b1;
            acc_d          = beat_word;
            cnt_d          = CW'(1);
            state_d        = st_eop ? S_PEND : S_PKT;
          end else if (st_eop) begin
            push           = 1'b1;
            push_word.data = acc_ins;
            push_word.bcnt = cnt_q + CW'(1);
            push_word.last = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
            state_d        = S_IDLE;
          end else if (cnt_q == CW'(NBEAT - 1)) begin
            push           = 1'b1;
            push_word.data = acc_ins;
            push_word.bcnt = CW'(NBEAT);
            acc_d          = '0;
            cnt_d          = '0;
          end else begin
            acc_d = acc_ins;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_PEND: begin
        // The held 1-beat packet waits for a free FIFO entry.
        if (!fifo_full) begin
          push           = 1'b1;
          push_word.data = acc_q;
          push_word.bcnt = cnt_q;
          push_word.last = 1'b1;
          acc_d          = '0;
          cnt_d          = '0;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef ST2BUS_SEQ_EN
    push_word.seq = seq_q;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

`ifdef ST2BUS_SEQ_EN
  // Sequence number of the packet currently being packed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q <= '0;
    end else if (push && push_word.last) begin
      seq_q <= seq_q + 16'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO. The packer never pushes into a full FIFO because
  // st_ready and the S_PEND push are both gated by fifo_full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only
  // observable once fifo_cnt covers it, and fifo_cnt is reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_st2bus_pack.sv
// -----------------------------------------------------------------------------
// tb_st2bus_pack
//
// Self-checking bench for st2bus_pack. A behavioural model turns the sequence
// of accepted beats into the list of words the host should see; a monitor
// compares every word handed to the host against that list. Directed checks
// cover reset values, first-word latency, back-pressure, stray beats, aborts
// and reset in the middle of a packet. Define ST2BUS_SEQ_EN to also check
// bus_seq.
// -----------------------------------------------------------------------------
module tb_st2bus_pack;

  localparam int ST       = 8;
  localparam int BUS_DATA = 512;
  localparam int NBEAT    = BUS_DATA / ST;
  localparam int CW       = $clog2(NBEAT + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [ST-1:0]       st_data;
  logic                st_valid;
  logic                st_sop;
  logic                st_eop;
  logic                st_ready;
  logic [BUS_DATA-1:0] bus_data;
  logic                bus_valid;
  logic                bus_last;
  logic [CW-1:0]       bus_bcnt;
  logic                bus_err;
  logic                bus_ready;
  logic                drop_pulse;
`ifdef ST2BUS_SEQ_EN
  logic [15:0]         bus_seq;
`endif

  always #5 clk = ~clk;

  st2bus_pack #(.ST(ST), .BUS_DATA(BUS_DATA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_data    (st_data),
    .st_valid   (st_valid),
    .st_sop     (st_sop),
    .st_eop     (st_eop),
    .st_ready   (st_ready),
    .bus_data   (bus_data),
    .bus_valid  (bus_valid),
    .bus_last   (bus_last),
    .bus_bcnt   (bus_bcnt),
    .bus_err    (bus_err),
    .bus_ready  (bus_ready),
    .drop_pulse (drop_pulse)
`ifdef ST2BUS_SEQ_EN
    ,
    .bus_seq    (bus_seq)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: packet bytes collected in a queue, words emitted by rule.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [BUS_DATA-1:0] data;
    int                  bcnt;
    bit                  last;
    bit                  err;
    int                  seq;
  } exp_word_t;

  exp_word_t     exp_q[$];
  logic [ST-1:0] cur[$];
  bit            open_pkt = 1'b0;
  int            seq_cnt  = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [BUS_DATA-1:0] obs,
                       input logic [BUS_DATA-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic emit(input bit last, input bit err);
    exp_word_t w;
    w.data = '0;
    foreach (cur[k]) w.data[k*ST +: ST] = cur[k];
    w.bcnt = cur.size();
    w.last = last;
    w.err  = err;
    w.seq  = seq_cnt;
    exp_q.push_back(w);
    if (last) seq_cnt = (seq_cnt + 1) % 65536;
    cur.delete();
  endtask

  task automatic model_beat(input logic [ST-1:0] d, input bit sop, input bit eop,
                            output bit dropped);
    dropped = 1'b0;
    if (!open_pkt) begin
      if (!sop) begin
        dropped = 1'b1;
        return;
      end
      open_pkt = 1'b1;
    end else if (sop) begin
      emit(1'b1, 1'b1);
    end
    cur.push_back(d);
    if (eop) begin
      emit(1'b1, 1'b0);
      open_pkt = 1'b0;
    end else if (cur.size() == NBEAT) begin
      emit(1'b0, 1'b0);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur.delete();
    open_pkt = 1'b0;
    seq_cnt  = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All called at posedge+1; inputs only change there.
  // ---------------------------------------------------------------------------
  task automatic send(input logic [ST-1:0] d, input bit sop, input bit eop,
                      input bit rand_ready);
    int waited;
    bit ok;
    bit dropped;
    waited = 0;
    ok     = 1'b0;
    if (rand_ready) bus_ready = ($urandom_range(0, 3) != 0);
    st_data  = d;
    st_sop   = sop;
    st_eop   = eop;
    st_valid = 1'b1;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (st_ready === 1'b1) begin
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
        waited++;
        if (rand_ready) bus_ready = ($urandom_range(0, 3) != 0);
      end
    end
    n_checks++;
    assert (ok) n_pass++;
    else $error("FAIL send_timeout: observed no st_ready after %0d cycles expected ready", waited);
    if (ok) begin
      @(posedge clk); #1;
      st_valid = 1'b0;
      model_beat(d, sop, eop, dropped);
    end else begin
      st_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus_ready = 1'b1;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    assert (exp_q.size() == 0) n_pass++;
    else $error("FAIL drain: observed %0d words outstanding expected 0", exp_q.size());
    @(posedge clk); #1;
    check("idle_after_drain", bus_valid, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every word taken by the host must match the model's next word.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    exp_word_t w;
    if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) n_pass++;
      else $error("FAIL unexpected_word: observed bcnt %0d expected no word", bus_bcnt);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word_data", bus_data, w.data);
        check("word_bcnt", bus_bcnt, w.bcnt);
        check("word_last", bus_last, w.last);
        check("word_err",  bus_err,  w.err);
`ifdef ST2BUS_SEQ_EN
        check("word_seq",  bus_seq,  w.seq);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed and randomized sequence.
  // ---------------------------------------------------------------------------
  initial begin
    logic [BUS_DATA-1:0] exp_w;
    logic [ST-1:0]       r0, r1, r2;

    rst_n     = 1'b0;
    st_data   = '0;
    st_valid  = 1'b0;
    st_sop    = 1'b0;
    st_eop    = 1'b0;
    bus_ready = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_st_ready",  st_ready,   1'b0);
    check("rst_bus_valid", bus_valid,  1'b0);
    check("rst_bus_data",  bus_data,   '0);
    check("rst_bus_bcnt",  bus_bcnt,   '0);
    check("rst_bus_last",  bus_last,   1'b0);
    check("rst_bus_err",   bus_err,    1'b0);
    check("rst_drop",      drop_pulse, 1'b0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", st_ready,  1'b1);
    check("post_rst_valid", bus_valid, 1'b0);
    @(posedge clk); #1;

    // 128-beat packet 0x00..0x7F: first word appears one cycle after beat 63.
    for (int i = 0; i < 128; i++) begin
      send(ST'(i), i == 0, i == 127, 1'b0);
      if (i == 62) check("lat_before_word", bus_valid, 1'b0);
      if (i == 63) begin
        check("lat_word_valid", bus_valid,          1'b1);
        check("w0_low_beat",    bus_data[7:0],      8'h00);
        check("w0_high_beat",   bus_data[511:504],  8'h3F);
        check("w0_bcnt",        bus_bcnt,           NBEAT);
        check("w0_last",        bus_last,           1'b0);
      end
      if (i == 127) begin
        check("w1_bcnt", bus_bcnt, NBEAT);
        check("w1_last", bus_last, 1'b1);
        check("w1_err",  bus_err,  1'b0);
      end
    end
    drain();

    // 3-beat packet.
    send(8'hA1, 1'b1, 1'b0, 1'b0);
    send(8'hA2, 1'b0, 1'b0, 1'b0);
    send(8'hA3, 1'b0, 1'b1, 1'b0);
    check("p3_data", bus_data, 512'hA3A2A1);
    check("p3_bcnt", bus_bcnt, 3);
    check("p3_last", bus_last, 1'b1);
    check("p3_err",  bus_err,  1'b0);
    drain();

    // 192-beat packet under back-pressure: FIFO fills after beat 128.
    bus_ready = 1'b0;
    for (int i = 0; i < 128; i++) send(ST'($urandom), i == 0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_st_ready_low", st_ready, 1'b0);
      check("bp_head_hold",    bus_data, exp_q[0].data);
      check("bp_bus_valid",    bus_valid, 1'b1);
      @(posedge clk); #1;
    end
    bus_ready = 1'b1;
    for (int i = 128; i < 192; i++) send(ST'($urandom), 1'b0, i == 191, 1'b0);
    drain();

    // Stray beat in IDLE.
    send(8'h55, 1'b0, 1'b0, 1'b0);
    check("drop_pulse_hi", drop_pulse, 1'b1);
    check("drop_no_word",  bus_valid,  1'b0);
    @(posedge clk); #1;
    check("drop_pulse_lo", drop_pulse, 1'b0);
    drain();

    // Abort after 10 beats, then a normal packet.
    for (int i = 0; i < 10; i++) send(ST'($urandom), i == 0, 1'b0, 1'b0);
    send(ST'($urandom), 1'b1, 1'b0, 1'b0);
    check("abort_bcnt", bus_bcnt, 10);
    check("abort_last", bus_last, 1'b1);
    check("abort_err",  bus_err,  1'b1);
    for (int i = 0; i < 4; i++) send(ST'($urandom), 1'b0, i == 3, 1'b0);
    drain();

    // Abort right after a full word: empty error word.
    for (int i = 0; i < NBEAT; i++) send(ST'($urandom), i == 0, 1'b0, 1'b0);
    send(ST'($urandom), 1'b1, 1'b0, 1'b0);
    check("abort0_bcnt", bus_bcnt, 0);
    check("abort0_err",  bus_err,  1'b1);
    check("abort0_data", bus_data, '0);
    send(ST'($urandom), 1'b0, 1'b1, 1'b0);
    drain();

    // Abort by a sop+eop beat: stream stalls one cycle for the 1-beat packet.
    for (int i = 0; i < 5; i++) send(ST'($urandom), i == 0, 1'b0, 1'b0);
    send(ST'($urandom), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("pend_ready_low", st_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("pend_ready_back", st_ready, 1'b1);
    @(posedge clk); #1;
    drain();

    // Reset mid-packet with one word queued.
    bus_ready = 1'b0;
    for (int i = 0; i < 70; i++) send(ST'($urandom), i == 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", st_ready,  1'b0);
    check("midrst_valid", bus_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check("after_rst_valid", bus_valid, 1'b0);
    bus_ready = 1'b1;
    r0 = ST'($urandom);
    r1 = ST'($urandom);
    r2 = ST'($urandom);
    send(r0, 1'b1, 1'b0, 1'b0);
    send(r1, 1'b0, 1'b0, 1'b0);
    send(r2, 1'b0, 1'b1, 1'b0);
    exp_w        = '0;
    exp_w[7:0]   = r0;
    exp_w[15:8]  = r1;
    exp_w[23:16] = r2;
    check("after_rst_data", bus_data, exp_w);
    check("after_rst_bcnt", bus_bcnt, 3);
`ifdef ST2BUS_SEQ_EN
    check("after_rst_seq",  bus_seq,  0);
`endif
    drain();

    // Randomized packets with random back-pressure, strays and aborts.
    for (int p = 0; p < 40; p++) begin
      int len;
      bit trunc;
      len   = $urandom_range(1, 140);
      trunc = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) send(ST'($urandom), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < len; i++)
        send(ST'($urandom), i == 0, (i == len - 1) && !trunc, 1'b1);
    end
    if (open_pkt) send(ST'($urandom), 1'b0, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
